// File: rtl/sample_gate.sv
// ----------------------------------------------------------------------------
// sample_gate
//   Front end of the IAGC phase path, sitting between the sampler and
//   phase_detector. Registers each reference/error sample pair and produces
//   the per-sample gate that phase_detector counts.
//
//   A gate window opens when |reference| reaches i_threshold. The window
//   lasts GATE_LENGTH valid samples, including the trigger sample. It is
//   followed by a hold-off of HOLDOFF_LENGTH valid samples. After the
//   hold-off the block re-arms, and it only opens a new window once the
//   reference has dropped below threshold again. A level held high therefore
//   never retriggers.
//
// Optional feature (macro SAMPLE_GATE_INVERT_EN):
//   When the macro is defined, an extra input i_invert_error is present.
//   While it is high, the captured error is -i_error, and the most negative
//   code saturates to the most positive one.
//   When the macro is not defined, the error is registered unmodified.
//
// Ports
//   i_clock         in   1   system clock
//   i_reset_n       in   1   asynchronous active-low reset
//   i_iagc_status   in   4   IAGC status, all-zero = IAGC in RESET
//   i_valid         in   1   sampler strobe, one new pair per high cycle
//   i_reference     in   14  reference sample (two's complement)
//   i_error         in   14  error sample (two's complement)
//   i_threshold     in   13  trigger magnitude (unsigned)
//   i_invert_error  in   1   negate captured error (SAMPLE_GATE_INVERT_EN)
//   o_reference     out  14  registered reference
//   o_error         out  14  registered (optionally negated) error
//   o_gate          out  1   one cycle high per in-window captured sample
//   o_pulse_count   out  16  gate windows opened since reset, wraps
// ----------------------------------------------------------------------------
module sample_gate #(
    parameter int SAMPLER_DATA_SIZE = 14,
    parameter int IAGC_STATUS_SIZE  = 4,
    parameter int GATE_LENGTH       = 50,
    parameter int HOLDOFF_LENGTH    = 16
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic [IAGC_STATUS_SIZE-1:0]    i_iagc_status,
    input  logic                           i_valid,
    input  logic [SAMPLER_DATA_SIZE-1:0]   i_reference,
    input  logic [SAMPLER_DATA_SIZE-1:0]   i_error,
    input  logic [SAMPLER_DATA_SIZE-2:0]   i_threshold,
`ifdef SAMPLE_GATE_INVERT_EN
    input  logic                           i_invert_error,
`endif
    output logic [SAMPLER_DATA_SIZE-1:0]   o_reference,
    output logic [SAMPLER_DATA_SIZE-1:0]   o_error,
    output logic                           o_gate,
    output logic [15:0]                    o_pulse_count
);

    localparam int D      = SAMPLER_DATA_SIZE;
    localparam int WIN_W  = $clog2(GATE_LENGTH + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_LENGTH + 1);

    // Extreme two's-complement codes. The most negative code has no positive
    // counterpart, so both abs and negate clamp it to the most positive code.
    localparam logic [D-1:0] S_MIN = {1'b1, {(D-1){1'b0}}};
    localparam logic [D-1:0] S_MAX = {1'b0, {(D-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_GATE,
        S_HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [WIN_W-1:0]  win_cnt, win_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              gate_nxt;
    logic              pulse_inc;
    logic              status_rst;
    logic [D-2:0]      ref_mag;
    logic              trig;
    logic [D-1:0]      err_cap;

    // Saturating magnitude. The result fits in D-1 bits because S_MIN is
    // clamped to S_MAX.
    function automatic logic [D-2:0] sat_abs(input logic [D-1:0] x);
        logic [D-1:0] n;
        if (x == S_MIN) begin
            n = S_MAX;
        end else if (x[D-1]) begin
            n = -x;
        end else begin
            n = x;
        end
        return n[D-2:0];
    endfunction

    // Saturating negate, used only by the error-inversion option.
    function automatic logic [D-1:0] sat_neg(input logic [D-1:0] x);
        logic [D-1:0] n;
        if (x == S_MIN) begin
            n = S_MAX;
        end else begin
            n = -x;
        end
        return n;
    endfunction

    assign status_rst = (i_iagc_status == '0);
    assign ref_mag    = sat_abs(i_reference);
    assign trig       = (ref_mag >= i_threshold);  // threshold 0 always triggers

`ifdef SAMPLE_GATE_INVERT_EN
    assign err_cap = i_invert_error ? sat_neg(i_error) : i_error;
`else
    assign err_cap = i_error;
`endif

    // ------------------------------------------------------------------
    // Next-state logic.
    // Every transition except IDLE exit and the status override is
    // qualified by i_valid. A gate is only produced on a valid sample,
    // so o_gate is automatically 0 in cycles without a fresh sample.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        win_cnt_nxt  = win_cnt;
        hold_cnt_nxt = hold_cnt;
        gate_nxt     = 1'b0;
        pulse_inc    = 1'b0;

        if (status_rst) begin
            // IAGC in RESET. An aborted window is dropped, not resumed.
            state_nxt    = S_IDLE;
            win_cnt_nxt  = '0;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_ARM;
                end

                S_ARM: begin
                    // Re-arm only after the reference has dropped below
                    // threshold. With threshold 0 that can never happen,
                    // so any valid sample arms.
                    if (i_valid && (!trig || (i_threshold == '0))) begin
                        state_nxt = S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (i_valid && trig) begin
                        gate_nxt  = 1'b1;
                        pulse_inc = 1'b1;
                        if (GATE_LENGTH == 1) begin
                            state_nxt    = S_HOLD;
                            win_cnt_nxt  = '0;
                            hold_cnt_nxt = '0;
                        end else begin
                            state_nxt   = S_GATE;
                            win_cnt_nxt = WIN_W'(1);
                        end
                    end
                end

                S_GATE: begin
                    // The window runs to length regardless of level or
                    // threshold changes.
                    if (i_valid) begin
                        gate_nxt = 1'b1;
                        if (win_cnt == WIN_W'(GATE_LENGTH - 1)) begin
                            state_nxt    = S_HOLD;
                            win_cnt_nxt  = '0;
                            hold_cnt_nxt = '0;
                        end else begin
                            win_cnt_nxt = win_cnt + WIN_W'(1);
                        end
                    end
                end

                S_HOLD: begin
                    if (i_valid) begin
                        if (hold_cnt == HOLD_W'(HOLDOFF_LENGTH - 1)) begin
                            state_nxt    = S_ARM;
                            hold_cnt_nxt = '0;
                        end else begin
                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    state_nxt    = S_IDLE;
                    win_cnt_nxt  = '0;
                    hold_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, counters and output registers.
    // Sample capture is independent of FSM state.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            win_cnt       <= '0;
            hold_cnt      <= '0;
            o_reference   <= '0;
            o_error       <= '0;
            o_gate        <= 1'b0;
            o_pulse_count <= '0;
        end else begin
            state    <= state_nxt;
            win_cnt  <= win_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            o_gate   <= gate_nxt;
            if (i_valid) begin
                o_reference <= i_reference;
                o_error     <= err_cap;
            end
            if (pulse_inc) begin
                o_pulse_count <= o_pulse_count + 16'd1;
            end
        end
    end

endmodule
